// File: rtl/router_pkg.sv
// Shared types and constants for the packet router controller.
package router_pkg;

  typedef logic [1:0] addr_t;

  localparam int    NUM_PORTS    = 3;
  localparam addr_t INVALID_ADDR = 2'd3;

  typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_e;

  typedef struct packed {
    logic [5:0] len;
    addr_t      addr;
  } hdr_t;

endpackage

// File: rtl/router_fifo.sv
// First-word-fall-through byte FIFO with extra-bit pointers; one per destination.
module router_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count;
  logic          do_wr, do_rd;

  always_comb begin
    count   = wptr_q - rptr_q;
    full    = (count == PW'(DEPTH));
    empty   = (count == '0);
    do_wr   = wr_en && !full;
    do_rd   = rd_en && !empty;
    wptr_d  = wptr_q + PW'(do_wr);
    rptr_d  = rptr_q + PW'(do_rd);
    // Empty FIFO presents zero so the head reads 0 out of reset.
    rd_data = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/router_ctrl.sv
// Header parser, parity checker and write steering for three destination FIFOs,
// with combinational backpressure toward a negedge-sampling sender.
module router_ctrl
  import router_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       packet_valid,
  input  logic [7:0] data,
  output logic       err,
  output logic       suspend_data_in,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2
);

  state_e     state_q, state_d;
  addr_t      addr_q, addr_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] par_q, par_d;
  logic       err_q, err_d;

  logic [NUM_PORTS-1:0] wr_en, rd_en, full, empty;
  logic [7:0]           dout [NUM_PORTS];
  logic [3:0]           full_x;
  hdr_t                 hdr;
  addr_t                dst;
  logic                 accept, wr;

  assign hdr    = hdr_t'(data);
  assign rd_en  = {read_enb_2, read_enb_1, read_enb_0};
  // Address 3 maps to a permanently not-full slot so it never stalls the sender.
  assign full_x = {1'b0, full};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    router_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en[i]),
      .wr_data (data),
      .rd_en   (rd_en[i]),
      .rd_data (dout[i]),
      .full    (full[i]),
      .empty   (empty[i])
    );
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    err_d   = 1'b0;
    wr      = 1'b0;
    dst     = (state_q == IDLE) ? hdr.addr : addr_q;
    suspend_data_in = packet_valid && (state_q != DROP) && full_x[dst];
    accept  = packet_valid && !suspend_data_in;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hdr.addr != INVALID_ADDR && hdr.len != '0) begin
            addr_d  = hdr.addr;
            cnt_d   = hdr.len;
            par_d   = data;
            wr      = 1'b1;
            state_d = PAYLOAD;
          end else begin
            err_d   = 1'b1;
            state_d = DROP;
          end
        end
      end
      PAYLOAD: begin
        if (!packet_valid) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (accept) begin
          wr    = 1'b1;
          par_d = par_q ^ data;
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = PARITY;
        end
      end
      PARITY: begin
        if (!packet_valid) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (accept) begin
          wr      = 1'b1;
          err_d   = (data != par_q);
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!packet_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < NUM_PORTS; i++) wr_en[i] = wr && (dst == addr_t'(i));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

  assign err        = err_q;
  assign vld_out_0  = !empty[0];
  assign vld_out_1  = !empty[1];
  assign vld_out_2  = !empty[2];
  assign data_out_0 = dout[0];
  assign data_out_1 = dout[1];
  assign data_out_2 = dout[2];

endmodule

// File: tb/tb_router_ctrl.sv
// Scoreboard bench for router_ctrl: sender drives on negedge, model tracks FIFO contents.
module tb_router_ctrl;
  import router_pkg::*;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset, packet_valid, err, suspend_data_in;
  logic [7:0] data;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;

  always #5 clock = ~clock;

  router_ctrl #(.DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .packet_valid    (packet_valid),
    .data            (data),
    .err             (err),
    .suspend_data_in (suspend_data_in),
    .vld_out_0       (vld_out_0),
    .vld_out_1       (vld_out_1),
    .vld_out_2       (vld_out_2),
    .data_out_0      (data_out_0),
    .data_out_1      (data_out_1),
    .data_out_2      (data_out_2),
    .read_enb_0      (read_enb_0),
    .read_enb_1      (read_enb_1),
    .read_enb_2      (read_enb_2)
  );

  int         checks = 0;
  int         failures = 0;
  int         occ [3];
  int         dut_pops [3];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic [7:0] pb [0:31];
  logic       err_pend = 1'b0;
  logic       acc_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_vld(input int p);
    case (p)
      0: return vld_out_0;
      1: return vld_out_1;
      default: return vld_out_2;
    endcase
  endfunction

  function automatic logic [7:0] get_dout(input int p);
    case (p)
      0: return data_out_0;
      1: return data_out_1;
      default: return data_out_2;
    endcase
  endfunction

  function automatic logic [7:0] pop_exp(input int p);
    occ[p]--;
    case (p)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void push_exp(input int p, input logic [7:0] b);
    occ[p]++;
    case (p)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endfunction

  // One sender cycle: drive at negedge, check just after, retire at posedge.
  task automatic cyc(input logic pv, input logic [7:0] d, input logic [2:0] rd,
                     input int dest, input logic e, output logic acc);
    logic       exp_s;
    logic [7:0] want;
    @(negedge clock);
    packet_valid = pv;
    data = d;
    {read_enb_2, read_enb_1, read_enb_0} = rd;
    #1;
    chk("err", err, err_pend);
    exp_s = 1'b0;
    if (pv && dest >= 0) exp_s = (occ[dest] == DEPTH);
    chk("suspend", suspend_data_in, exp_s);
    for (int p = 0; p < 3; p++) begin
      if (rd[p]) begin
        chk($sformatf("vld%0d", p), get_vld(p), occ[p] > 0);
        if (occ[p] > 0) begin
          if (get_vld(p)) dut_pops[p]++;
          want = pop_exp(p);
          chk($sformatf("data_out%0d", p), get_dout(p), want);
        end
      end
    end
    acc = pv && !exp_s;
    if (acc && dest >= 0) push_exp(dest, d);
    err_pend = e && (acc || !pv);
    @(posedge clock);
  endtask

  task automatic send_byte(input logic [7:0] d, input int dest, input logic e, input logic pop_full);
    logic       acc;
    logic [2:0] rd;
    int         g;
    acc = 1'b0;
    g = 0;
    while (!acc) begin
      rd = 3'b000;
      if (pop_full && dest >= 0 && occ[dest] == DEPTH) rd = 3'(1 << dest);
      cyc(1'b1, d, rd, dest, e, acc);
      g++;
      if (!acc && g > 100) begin
        chk("stall_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int n, input logic bad_par, input logic pop_full);
    logic [7:0] par;
    int         dest;
    dest = int'(hdr[1:0]);
    par  = hdr;
    send_byte(hdr, dest, 1'b0, pop_full);
    for (int i = 0; i < n; i++) begin
      par ^= pb[i];
      send_byte(pb[i], dest, 1'b0, pop_full);
    end
    send_byte(bad_par ? ~par : par, dest, bad_par, pop_full);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 3'b000, -1, 1'b0, acc);
  endtask

  task automatic drain(input int p);
    logic acc;
    int   g;
    g = 0;
    while (occ[p] > 0 && g < 100) begin
      cyc(1'b0, 8'h00, 3'(1 << p), -1, 1'b0, acc);
      g++;
    end
    cyc(1'b0, 8'h00, 3'(1 << p), -1, 1'b0, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    packet_valid = 1'b0;
    data = 8'h00;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    for (int p = 0; p < 3; p++) begin
      occ[p] = 0;
      dut_pops[p] = 0;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("rst_err", err, 0);
    chk("rst_suspend", suspend_data_in, 0);
    chk("rst_vld0", vld_out_0, 0);
    chk("rst_vld1", vld_out_1, 0);
    chk("rst_vld2", vld_out_2, 0);
    chk("rst_dout0", data_out_0, 0);
    chk("rst_dout1", data_out_1, 0);
    chk("rst_dout2", data_out_2, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clock);
    reset = 1'b1;

    // Good packet to port 1.
    pb[0] = 8'hA1; pb[1] = 8'hB2; pb[2] = 8'hC3;
    send_pkt(8'h0D, 3, 1'b0, 1'b0);
    idle(1);
    chk("t1_vld1", vld_out_1, 1);
    chk("t1_vld0", vld_out_0, 0);
    chk("t1_vld2", vld_out_2, 0);
    chk("t1_pops_before", dut_pops[1], 0);
    drain(1);
    chk("t1_pops", dut_pops[1], 5);

    // Same packet, corrupted parity byte.
    send_pkt(8'h0D, 3, 1'b1, 1'b0);
    idle(2);
    drain(1);
    chk("t2_pops", dut_pops[1], 10);

    // Invalid address then a following packet to port 0.
    cyc(1'b1, 8'h07, 3'b000, -1, 1'b1, acc_m);
    cyc(1'b1, 8'h55, 3'b000, -1, 1'b0, acc_m);
    cyc(1'b0, 8'h00, 3'b000, -1, 1'b0, acc_m);
    #2;
    chk("t3_vld0", vld_out_0, 0);
    chk("t3_vld1", vld_out_1, 0);
    chk("t3_vld2", vld_out_2, 0);
    pb[0] = 8'h11; pb[1] = 8'h22;
    send_pkt(8'h08, 2, 1'b0, 1'b0);
    idle(1);
    drain(0);

    // 20-byte packet into a 16-deep FIFO, popping only while full.
    for (int i = 0; i < 18; i++) pb[i] = 8'(i * 7 + 3);
    send_pkt(8'h4A, 18, 1'b0, 1'b1);
    idle(1);
    drain(2);
    chk("t4_total", dut_pops[2], 20);

    // Truncated packet, then a back-to-back header.
    pb[0] = 8'hA1; pb[1] = 8'hB2;
    send_byte(8'h0D, 1, 1'b0, 1'b0);
    send_byte(pb[0], 1, 1'b0, 1'b0);
    send_byte(pb[1], 1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 3'b000, -1, 1'b1, acc_m);
    pb[0] = 8'h77;
    send_pkt(8'h06, 1, 1'b0, 1'b0);
    idle(1);
    drain(1);
    drain(2);

    // Reset in the middle of a payload with six bytes in port 0.
    for (int i = 0; i < 10; i++) pb[i] = 8'(8'h30 + i);
    send_byte(8'h28, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(pb[i], 0, 1'b0, 1'b0);
    @(negedge clock);
    packet_valid = 1'b1;
    data = pb[5];
    reset = 1'b0;
    #1;
    chk("t6_vld0", vld_out_0, 0);
    chk("t6_dout0", data_out_0, 0);
    chk("t6_err", err, 0);
    chk("t6_state", 32'(dut.state_q), 32'(IDLE));
    q0.delete();
    occ[0] = 0;
    err_pend = 1'b0;
    @(posedge clock);
    @(negedge clock);
    packet_valid = 1'b0;
    reset = 1'b1;
    pb[0] = 8'h5A;
    send_pkt(8'h04, 1, 1'b0, 1'b0);
    idle(1);
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
